// File: rtl/pla_stream_eval.sv
// ============================================================================
// Module      : pla_stream_eval
// Description : Streaming sum-of-products (PLA) evaluator. A runtime-loaded
//               cube table is evaluated against an input vector stream
//               through a two-stage valid/ready pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pla_stream_eval #(
    parameter int N_IN   = 8,
    parameter int N_CUBE = 16,
    parameter int N_OUT  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_we,
    input  logic [$clog2(N_CUBE)-1:0]            cfg_addr,
    input  logic [N_IN-1:0]                      cfg_care,
    input  logic [N_IN-1:0]                      cfg_val,
    input  logic [N_OUT-1:0]                     cfg_out,
    input  logic                                 cfg_mask_we,
    input  logic [N_IN-1:0]                      cfg_mask,
    input  logic                                 cfg_clr,
    output logic                                 cfg_ready,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_IN-1:0]                      in_x,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [N_OUT-1:0]                     out_y
);

    localparam int C_ADDR_W = $clog2(N_CUBE);

    logic [N_IN-1:0]   r_care [N_CUBE];
    logic [N_IN-1:0]   r_val  [N_CUBE];
    logic [N_OUT-1:0]  r_out  [N_CUBE];
    logic [N_CUBE-1:0] r_cube_valid;
    logic [N_IN-1:0]   r_mask;

    logic              r_s1_valid;
    logic [N_IN-1:0]   r_s1_x;
    logic              r_s2_valid;
    logic [N_OUT-1:0]  r_s2_y;

    logic              w_cfg_ok;
    logic              w_cfg_strobe;
    logic              w_s2_ready;
    logic              w_s1_ready;
    logic              w_in_fire;
    logic [N_CUBE-1:0] w_match;
    logic [N_IN-1:0]   w_x_xlat;
    logic [N_OUT-1:0]  w_eval;

    // Configuration is only accepted while the datapath is idle, so table
    // updates can never race an in-flight vector.
    assign cfg_ready    = !r_s1_valid && !r_s2_valid && !in_valid;
    assign w_cfg_strobe = cfg_we || cfg_mask_we || cfg_clr;
    assign w_cfg_ok     = cfg_ready && rst_n;

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign in_ready   = rst_n && w_s1_ready && !(w_cfg_ok && w_cfg_strobe);
    assign w_in_fire  = in_valid && in_ready;

    assign out_valid = r_s2_valid && rst_n;
    assign out_y     = rst_n ? r_s2_y : '0;

    assign w_x_xlat = r_s1_x ^ r_mask;

    genvar k;
    generate
        for (k = 0; k < N_CUBE; k++) begin : g_cube
            assign w_match[k] = r_cube_valid[k] &&
                                ((w_x_xlat ^ r_val[k]) & r_care[k]) == '0;
        end
    endgenerate

    always_comb begin
        w_eval = '0;
        for (int i = 0; i < N_CUBE; i++) begin
            if (w_match[i]) begin
                w_eval = w_eval | r_out[i];
            end
        end
    end

    // Table payload needs no reset: entries are qualified by r_cube_valid.
    always_ff @(posedge clk) begin
        if (w_cfg_ok && cfg_we) begin
            r_care[cfg_addr] <= cfg_care;
            r_val[cfg_addr]  <= cfg_val;
            r_out[cfg_addr]  <= cfg_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cube_valid <= '0;
            r_mask       <= '0;
        end else if (w_cfg_ok) begin
            // Later assignment wins, giving clear-then-write ordering.
            if (cfg_clr) begin
                r_cube_valid <= '0;
            end
            if (cfg_we) begin
                r_cube_valid[cfg_addr] <= 1'b1;
            end
            if (cfg_mask_we) begin
                r_mask <= cfg_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
        end else begin
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_y <= w_eval;
                end
            end
            if (w_s1_ready) begin
                r_s1_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_s1_x <= in_x;
                end
            end
        end
    end

    logic [C_ADDR_W-1:0] w_unused_addr_w;
    assign w_unused_addr_w = cfg_addr;

endmodule

`default_nettype wire

// File: tb/tb_pla_stream_eval.sv
// ============================================================================
// Module      : tb_pla_stream_eval
// Description : Directed self-checking bench for pla_stream_eval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pla_stream_eval;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_care;
    logic [7:0] cfg_val;
    logic [0:0] cfg_out;
    logic       cfg_mask_we;
    logic [7:0] cfg_mask;
    logic       cfg_clr;
    logic       cfg_ready;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] out_y;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pla_stream_eval #(.N_IN(8), .N_CUBE(16), .N_OUT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_care    (cfg_care),
        .cfg_val     (cfg_val),
        .cfg_out     (cfg_out),
        .cfg_mask_we (cfg_mask_we),
        .cfg_mask    (cfg_mask),
        .cfg_clr     (cfg_clr),
        .cfg_ready   (cfg_ready),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_cube(input logic clr, input logic we, input logic [3:0] a,
                            input logic [7:0] care, input logic [7:0] val, input logic o);
        cfg_clr  = clr;
        cfg_we   = we;
        cfg_addr = a;
        cfg_care = care;
        cfg_val  = val;
        cfg_out  = o;
        tick();
        cfg_clr  = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic set_mask(input logic [7:0] m);
        cfg_mask_we = 1'b1;
        cfg_mask    = m;
        tick();
        cfg_mask_we = 1'b0;
    endtask

    // One isolated transaction: accept, one cycle in S1, result in S2.
    task automatic send(input string tag, input logic [7:0] x, input logic exp);
        in_valid = 1'b1;
        in_x     = x;
        #1;
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk({tag, "_lat"}, out_valid, 0);
        tick();
        chk({tag, "_ov"}, out_valid, 1);
        chk(tag, out_y, exp);
        tick();
    endtask

    logic [7:0] sx [3] = '{8'h3C, 8'h3D, 8'h3C};
    logic       se [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] bv [4] = '{8'h3D, 8'h3C, 8'h3D, 8'h3C};
    logic       be [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       got [4];
    int         idx;
    int         nout;
    logic       acc;

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0;
        cfg_out = '0; cfg_mask_we = 1'b0; cfg_mask = '0; cfg_clr = 1'b0;
        in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_ov", out_valid, 0);
        chk("rst_y", out_y, 0);
        chk("rst_irdy", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_irdy", in_ready, 1);
        chk("rel_crdy", cfg_ready, 1);
        in_valid = 1'b1;
        #1;
        chk("rel_crdy_iv", cfg_ready, 0);
        in_valid = 1'b0;
        tick();

        send("nocube", 8'hA5, 0);

        cfg_cube(0, 1, 4'd0, 8'hFF, 8'h3C, 1);
        for (int t = 0; t < 6; t++) begin
            in_valid = (t < 3);
            if (t < 3) in_x = sx[t];
            #1;
            if (t < 3) chk("bb_rdy", in_ready, 1);
            tick();
            if (t >= 1 && t <= 3) begin
                chk("bb_ov", out_valid, 1);
                chk("bb_y", out_y, se[t-1]);
            end else begin
                chk("bb_ov0", out_valid, 0);
            end
        end

        set_mask(8'h01);
        send("mask_3d", 8'h3D, 1);
        send("mask_3c", 8'h3C, 0);

        // Backpressure: stall the sink and hold the stream.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            in_x     = bv[idx];
            #1;
            if (c >= 2) begin
                chk("stall_ov", out_valid, 1);
                chk("stall_y", out_y, 1);
                chk("stall_irdy", in_ready, 0);
            end
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        chk("stall_acc", idx, 2);
        out_ready = 1'b1;
        nout = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) in_x = bv[idx];
            #1;
            if (out_valid) begin
                if (nout < 4) got[nout] = out_y;
                nout++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_count", nout, 4);
        for (int i = 0; i < 4; i++) chk("bp_order", got[i], be[i]);

        // Write while a vector is offered must be dropped.
        in_valid = 1'b1;
        in_x     = 8'h01;
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_care = 8'hFF;
        cfg_val  = 8'h00;
        cfg_out  = 1'b1;
        #1;
        chk("ign_crdy", cfg_ready, 0);
        chk("ign_irdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        tick();
        chk("ign_ov", out_valid, 1);
        chk("ign_y", out_y, 0);
        tick();
        send("ign_01", 8'h01, 0);
        send("ign_3d", 8'h3D, 1);

        cfg_clr  = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 4'd3;
        cfg_care = 8'h00;
        cfg_val  = 8'h00;
        cfg_out  = 1'b1;
        #1;
        chk("cw_crdy", cfg_ready, 1);
        chk("cw_irdy", in_ready, 0);
        tick();
        cfg_clr = 1'b0;
        cfg_we  = 1'b0;
        send("taut_00", 8'h00, 1);
        send("taut_ff", 8'hFF, 1);
        send("taut_5a", 8'h5A, 1);

        cfg_cube(1, 0, 4'd0, 8'h00, 8'h00, 0);
        send("clr_empty", 8'h3D, 0);
        cfg_cube(0, 1, 4'd5, 8'hFF, 8'h11, 1);
        cfg_cube(0, 1, 4'd5, 8'hFF, 8'h22, 1);
        send("lww_old", 8'h10, 0);
        send("lww_new", 8'h23, 1);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 8'h23;
        tick();
        tick();
        in_valid = 1'b0;
        #1;
        chk("full_ov", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_ov", out_valid, 0);
        chk("mrst_y", out_y, 0);
        chk("mrst_irdy", in_ready, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mrel_irdy", in_ready, 1);
        chk("mrel_crdy", cfg_ready, 1);
        for (int c = 0; c < 3; c++) begin
            chk("mrel_stale", out_valid, 0);
            tick();
        end
        send("mrel_22", 8'h22, 0);
        send("mrel_23", 8'h23, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pla_stream_eval.md
PLA_STREAM_EVAL -- requirements
Module: pla_stream_eval

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning input vector width (2..16).
REQ-002 SHALL have parameter N_CUBE, default 16, meaning cube table depth (power of two, 2..64).
REQ-003 SHALL have parameter N_OUT, default 1, meaning output vector width (1..8).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 SHALL have port cfg_we  input  1  cube-table write strobe.
REQ-007 SHALL have port cfg_addr  input  log2(N_CUBE)  cube index to write.
REQ-008 SHALL have port cfg_care  input  N_IN  literal-present mask of the cube (1 = bit tested).
REQ-009 SHALL have port cfg_val  input  N_IN  required literal polarity for cared bits.
REQ-010 SHALL have port cfg_out  input  N_OUT  outputs to which the cube contributes.
REQ-011 SHALL have port cfg_mask_we  input  1  write strobe for the input translation mask.
REQ-012 SHALL have port cfg_mask  input  N_IN  translation mask value.
REQ-013 SHALL have port cfg_clr  input  1  invalidate all cubes.
REQ-014 SHALL have port cfg_ready  output  1  high when the configuration port accepts writes.
REQ-015 SHALL have port in_valid / in_ready / in_x  input / output / N_IN  input vector stream.
REQ-016 SHALL have port out_valid / out_ready / out_y  output / input / N_OUT  result stream.

Function
REQ-017 SHALL contain a two-stage pipeline: S1 holds the accepted vector, S2 holds the evaluated result.
REQ-018 SHALL transfer on in_valid & in_ready; out_y SHALL appear with out_valid exactly 2 cycles after acceptance when out_ready stays high.
REQ-019 SHALL evaluate in S1: cube k matches when valid[k] and ((x ^ mask) ^ val[k]) & care[k] == 0; out_y[j] = OR of matches k with out[k][j]; zero valid cubes gives out_y = 0.
REQ-020 SHALL treat a cube with care = 0 as a tautology (always matches when valid).
REQ-021 SHALL hold S2 while out_valid & !out_ready; S1 SHALL advance only when S2 is empty or draining; in_ready = !S1_valid | S1 advancing.
REQ-022 SHALL sustain one vector per cycle with out_ready constantly high; no bubbles, no duplicates, no drops.
REQ-023 SHALL drive cfg_ready = !S1_valid & !S2_valid & !in_valid.
REQ-024 SHALL ignore cfg_we, cfg_mask_we, cfg_clr in any cycle where cfg_ready is low.
REQ-025 SHALL force in_ready low in any cycle where an accepted config strobe is asserted.
REQ-026 SHALL, on accepted cfg_we, write care/val/out at cfg_addr and set valid[cfg_addr]; effective for vectors accepted after that cycle.
REQ-027 SHALL, on simultaneous accepted cfg_clr and cfg_we, apply clear first then the write (only cfg_addr valid afterwards).
REQ-028 SHALL rewrite an already valid entry in place (last write wins).
REQ-029 SHALL keep out_y stable while out_valid & !out_ready.

Reset
REQ-030 SHALL, when rst_n is low at a clock edge, clear S1_valid, S2_valid, all cube valid bits and mask; out_valid = 0, out_y = 0, in_ready = 0 during that cycle.
REQ-031 SHALL discard in-flight vectors on reset mid-stream; no output for them afterwards.
REQ-032 SHALL drive in_ready = 1 and cfg_ready = !in_valid from the first cycle after reset release.

Verification
REQ-033 SHALL pass: reset, no cubes, send x = 8'hA5 -> out_y = 0 two cycles later.
REQ-034 SHALL pass: cube0 care=8'hFF val=8'h3C out=1, stream 8'h3C, 8'h3D, 8'h3C back-to-back -> out_y 1,0,1 on consecutive cycles.
REQ-035 SHALL pass: cube0 as above, mask=8'h01, x=8'h3D -> out_y = 1; x=8'h3C -> 0.
REQ-036 SHALL pass: out_ready low 5 cycles with stream pending -> in_ready low after S1 fills, out_y held, all vectors delivered in order after release.
REQ-037 SHALL pass: cfg_we pulse while in_valid high -> write ignored, table unchanged; cfg_clr + cfg_we(addr 3, care=0) together -> only cube 3 valid, every x gives out_y = 1.
REQ-038 SHALL pass: rst_n low for 1 cycle with both stages full -> out_valid 0 next cycle, no stale output, prior cubes no longer match.
